// File: rtl/brief_desc_collector.sv
// Buffers one frame of BRIEF keypoints and streams it to the host as a header word plus
// 9 words per keypoint. Optional score gate: define BRIEF_COLLECT_MIN_SCORE_EN.
module brief_desc_collector #(
   parameter int MAX_KP     = 256,
   parameter int FRAME_ID_W = 15
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_valid,
   input  logic         i_start,
   input  logic         i_end,
   input  logic         i_flag,
   input  logic [9:0]   i_coor_x,
   input  logic [9:0]   i_coor_y,
   input  logic [7:0]   i_score,
   input  logic [255:0] i_descriptor,
`ifdef BRIEF_COLLECT_MIN_SCORE_EN
   input  logic [7:0]   i_min_score,
`endif
   output logic [31:0]  o_word,
   output logic         o_valid,
   input  logic         i_ready,
   output logic         o_last,
   output logic         o_busy,
   output logic [15:0]  o_drop_count
);
   localparam int IW = $clog2(MAX_KP);
   localparam int CW = IW + 1;
   localparam int EW = 284;

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_HEADER, S_ENTRY} state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         count_q, count_d;
   logic [IW-1:0]         rd_idx_q, rd_idx_d;
   logic [3:0]            word_idx_q, word_idx_d;
   logic [FRAME_ID_W-1:0] frame_id_q, frame_id_d;
   logic                  overflow_q, overflow_d;
   logic [15:0]           drop_q, drop_d;
   logic [31:0]           word_q, word_d;
   logic                  valid_q, valid_d;
   logic                  last_q, last_d;
   logic                  busy_q, busy_d;

   // entry layout {score, y, x, descriptor}
   logic [EW-1:0] buf_mem [MAX_KP];
   logic          wr_en;
   logic [IW-1:0] wr_idx;
   logic [EW-1:0] entry;
   logic          cand, xfer, drop_inc;

`ifdef BRIEF_COLLECT_MIN_SCORE_EN
   logic [7:0] min_q, min_d;
   logic [7:0] thr;
   // the start cycle itself already uses the incoming threshold
   assign thr  = (state_q == S_IDLE) ? i_min_score : min_q;
   assign cand = i_valid && i_flag && (i_score >= thr);
`else
   assign cand = i_valid && i_flag;
`endif

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      rd_idx_d   = rd_idx_q;
      word_idx_d = word_idx_q;
      frame_id_d = frame_id_q;
      overflow_d = overflow_q;
      drop_inc   = 1'b0;
      wr_en      = 1'b0;
      wr_idx     = count_q[IW-1:0];
      xfer       = valid_q && i_ready;
`ifdef BRIEF_COLLECT_MIN_SCORE_EN
      min_d      = min_q;
`endif
      case (state_q)
         S_IDLE: if (i_valid && i_start) begin
            state_d    = S_COLLECT;
            overflow_d = 1'b0;
            count_d    = '0;
            wr_idx     = '0;
`ifdef BRIEF_COLLECT_MIN_SCORE_EN
            min_d      = i_min_score;
`endif
            if (cand) begin
               wr_en   = 1'b1;
               count_d = CW'(1);
            end
         end
         S_COLLECT: begin
            if (cand) begin
               if (count_q < CW'(MAX_KP)) begin
                  wr_en   = 1'b1;
                  count_d = count_q + CW'(1);
               end else begin
                  overflow_d = 1'b1;
               end
            end
            if (i_valid && (i_end || i_start)) begin
               state_d  = S_HEADER;
               drop_inc = i_start;
            end
         end
         S_HEADER: begin
            drop_inc = i_valid && i_start;
            if (xfer) begin
               if (count_q == '0) begin
                  state_d    = S_IDLE;
                  frame_id_d = frame_id_q + FRAME_ID_W'(1);
               end else begin
                  state_d    = S_ENTRY;
                  rd_idx_d   = '0;
                  word_idx_d = '0;
               end
            end
         end
         S_ENTRY: begin
            drop_inc = i_valid && i_start;
            if (xfer) begin
               if (word_idx_q != 4'd8) begin
                  word_idx_d = word_idx_q + 4'd1;
               end else if ({1'b0, rd_idx_q} == count_q - CW'(1)) begin
                  state_d    = S_IDLE;
                  frame_id_d = frame_id_q + FRAME_ID_W'(1);
               end else begin
                  rd_idx_d   = rd_idx_q + IW'(1);
                  word_idx_d = '0;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      drop_d = (drop_inc && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;

      // outputs are registered from the next-state view, so they only move on a transfer
      entry   = buf_mem[rd_idx_d];
      valid_d = (state_d == S_HEADER) || (state_d == S_ENTRY);
      busy_d  = valid_d;
      word_d  = '0;
      last_d  = 1'b0;
      if (state_d == S_HEADER) begin
         word_d = {overflow_d, 15'(frame_id_d), 16'(count_d)};
         last_d = (count_d == '0);
      end else if (state_d == S_ENTRY) begin
         if (word_idx_d == 4'd0) word_d = {4'b0, entry[EW-1:256]};
         else                    word_d = entry[(int'(word_idx_d) - 1) * 32 +: 32];
         last_d = (word_idx_d == 4'd8) && ({1'b0, rd_idx_d} == count_d - CW'(1));
      end
   end

   always_ff @(posedge i_clk) begin
      if (wr_en) buf_mem[wr_idx] <= {i_score, i_coor_y, i_coor_x, i_descriptor};
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= S_IDLE;
         count_q    <= '0;
         rd_idx_q   <= '0;
         word_idx_q <= '0;
         frame_id_q <= '0;
         overflow_q <= 1'b0;
         drop_q     <= '0;
         word_q     <= '0;
         valid_q    <= 1'b0;
         last_q     <= 1'b0;
         busy_q     <= 1'b0;
`ifdef BRIEF_COLLECT_MIN_SCORE_EN
         min_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         rd_idx_q   <= rd_idx_d;
         word_idx_q <= word_idx_d;
         frame_id_q <= frame_id_d;
         overflow_q <= overflow_d;
         drop_q     <= drop_d;
         word_q     <= word_d;
         valid_q    <= valid_d;
         last_q     <= last_d;
         busy_q     <= busy_d;
`ifdef BRIEF_COLLECT_MIN_SCORE_EN
         min_q      <= min_d;
`endif
      end
   end

   assign o_word       = word_q;
   assign o_valid      = valid_q;
   assign o_last       = last_q;
   assign o_busy       = busy_q;
   assign o_drop_count = drop_q;

endmodule

// File: tb/tb_brief_desc_collector.sv
// Randomized bench for brief_desc_collector: a keypoint-queue model builds each expected packet.
module tb_brief_desc_collector;
   localparam int MAX_KP = 4;

   typedef struct packed {
      logic [7:0]   sc;
      logic [9:0]   y;
      logic [9:0]   x;
      logic [255:0] d;
   } kp_t;

   logic         i_clk = 1'b0, i_rst_n = 1'b0;
   logic         i_valid = 1'b0, i_start = 1'b0, i_end = 1'b0, i_flag = 1'b0;
   logic [9:0]   i_coor_x = '0, i_coor_y = '0;
   logic [7:0]   i_score = '0;
   logic [255:0] i_descriptor = '0;
   logic         i_ready = 1'b1;
   logic [31:0]  o_word;
   logic         o_valid, o_last, o_busy;
   logic [15:0]  o_drop_count;

   always #5 i_clk = ~i_clk;

   brief_desc_collector #(.MAX_KP(MAX_KP), .FRAME_ID_W(15)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_start(i_start), .i_end(i_end),
      .i_flag(i_flag), .i_coor_x(i_coor_x), .i_coor_y(i_coor_y), .i_score(i_score),
      .i_descriptor(i_descriptor),
`ifdef BRIEF_COLLECT_MIN_SCORE_EN
      .i_min_score(8'd0),
`endif
      .o_word(o_word), .o_valid(o_valid), .i_ready(i_ready), .o_last(o_last),
      .o_busy(o_busy), .o_drop_count(o_drop_count));

   int          n_vec = 0, n_err = 0;
   logic [31:0] exp_w[$];
   logic        exp_l[$];
   logic [31:0] pkt[$];
   kp_t         kq[$];
   logic        ovf = 1'b0;
   int          fid = 0, drops = 0;
   bit          in_frame = 1'b0;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic kp_t rkp();
      kp_t k;
      k.sc = 8'($urandom); k.y = 10'($urandom); k.x = 10'($urandom);
      k.d  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      return k;
   endfunction

   function automatic kp_t mk(int x, int y, int s);
      kp_t k = rkp();
      k.x = 10'(x); k.y = 10'(y); k.sc = 8'(s);
      return k;
   endfunction

   // one cycle: transfers are those with valid&&ready just before the edge
   task automatic step();
      logic xf, st, l;
      logic [31:0] w;
      xf = o_valid && i_ready;
      st = o_valid && !i_ready;
      w  = o_word;
      l  = o_last;
      @(posedge i_clk); #1;
      if (xf) begin
         pkt.push_back(w);
         if (exp_w.size() == 0) chk("spurious_xfer", {31'b0, xf}, 32'd0);
         else begin
            chk("word", w, exp_w.pop_front());
            chk("last", {31'b0, l}, {31'b0, exp_l.pop_front()});
         end
      end
      if (st) begin
         chk("hold_word", o_word, w);
         chk("hold_valid", {31'b0, o_valid}, 32'd1);
         chk("hold_last", {31'b0, o_last}, {31'b0, l});
      end
   endtask

   task automatic expect_frame();
      exp_w.push_back({ovf, 15'(fid), 16'(kq.size())});
      exp_l.push_back(kq.size() == 0);
      foreach (kq[i]) begin
         exp_w.push_back({4'b0, kq[i].sc, kq[i].y, kq[i].x});
         exp_l.push_back(1'b0);
         for (int k = 0; k < 8; k++) begin
            exp_w.push_back(kq[i].d[32*k +: 32]);
            exp_l.push_back(i == kq.size() - 1 && k == 7);
         end
      end
      fid = (fid + 1) % 32768;
   endtask

   task automatic take(bit f, kp_t k);
      if (f) begin
         if (kq.size() < MAX_KP) kq.push_back(k);
         else ovf = 1'b1;
      end
   endtask

   // drive one cycle while idle or collecting, updating the model
   task automatic put(bit v, bit s, bit e, bit f, kp_t k);
      bit closing = 1'b0;
      i_valid = v; i_start = s; i_end = e; i_flag = f;
      {i_score, i_coor_y, i_coor_x, i_descriptor} = k;
      if (v) begin
         if (!in_frame) begin
            if (s) begin in_frame = 1'b1; kq.delete(); ovf = 1'b0; take(f, k); end
         end else begin
            take(f, k);
            if (e || s) begin
               in_frame = 1'b0;
               closing  = 1'b1;
               if (s && drops < 65535) drops++;
               expect_frame();
            end
         end
      end
      step();
      if (closing) begin
         chk("hdr_latency", {31'b0, o_valid}, 32'd1);
         chk("busy", {31'b0, o_busy}, 32'd1);
      end
   endtask

   task automatic idle();
      i_valid = 1'b0; i_start = 1'b0; i_end = 1'b0; i_flag = 1'b0;
   endtask

   // read out the packet; junk end/flag is driven and one start may be injected at cycle inj
   task automatic drain(bit rnd, int inj);
      int n = 0;
      pkt.delete();
      while (exp_w.size() != 0 && n < 3000) begin
         i_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         i_valid = 1'($urandom_range(0, 1));
         i_end   = 1'($urandom_range(0, 1));
         i_flag  = 1'($urandom_range(0, 1));
         i_start = (n == inj);
         if (i_start) i_valid = 1'b1;
         if (i_valid && i_start && drops < 65535) drops++;
         {i_score, i_coor_y, i_coor_x, i_descriptor} = rkp();
         step();
         n++;
      end
      chk("drain_left", 32'(exp_w.size()), 32'd0);
      exp_w.delete(); exp_l.delete();
      idle();
      i_ready = 1'b1;
      step();
      chk("post_valid", {31'b0, o_valid}, 32'd0);
      chk("post_busy", {31'b0, o_busy}, 32'd0);
      chk("drops", {16'b0, o_drop_count}, 32'(drops));
   endtask

   task automatic tp_frame();
      put(1, 1, 0, 0, rkp());
      put(1, 0, 0, 1, mk(5, 7, 20));
      put(1, 0, 0, 1, mk(100, 200, 30));
      put(1, 0, 0, 1, mk(639, 479, 255));
      put(1, 0, 1, 0, rkp());
   endtask

   initial begin
      repeat (3) @(posedge i_clk);
      #1;
      chk("rst_word", o_word, 32'd0);
      chk("rst_valid", {31'b0, o_valid}, 32'd0);
      chk("rst_last", {31'b0, o_last}, 32'd0);
      chk("rst_busy", {31'b0, o_busy}, 32'd0);
      chk("rst_drop", {16'b0, o_drop_count}, 32'd0);
      i_rst_n = 1'b1;
      step();

      tp_frame();
      drain(0, -1);
      chk("tp_len", 32'(pkt.size()), 32'd28);
      chk("tp_hdr", pkt[0], 32'h0000_0003);
      chk("tp_e0w0", pkt[1], 32'h0140_1C05);

      put(1, 0, 1, 1, rkp());
      chk("idle_end_ignored", {31'b0, o_valid}, 32'd0);
      put(1, 1, 0, 0, rkp()); put(1, 0, 1, 0, rkp());
      drain(0, -1);
      chk("empty_hdr1", pkt[0], 32'h0001_0000);
      put(1, 1, 0, 0, rkp()); put(1, 0, 1, 0, rkp());
      drain(0, -1);
      chk("empty_hdr2", pkt[0], 32'h0002_0000);

      put(1, 1, 0, 1, rkp());
      repeat (5) put(1, 0, 0, 1, rkp());
      put(1, 0, 1, 0, rkp());
      drain(0, -1);
      chk("ovf_len", 32'(pkt.size()), 32'd37);
      chk("ovf_hdr", pkt[0], 32'h8003_0004);

      tp_frame();
      drain(1, -1);
      chk("bp_len", 32'(pkt.size()), 32'd28);

      put(1, 1, 0, 0, rkp()); put(1, 0, 0, 1, rkp()); put(1, 0, 0, 1, rkp());
      put(1, 1, 1, 1, rkp());
      chk("drop_b2b", {16'b0, o_drop_count}, 32'd1);
      drain(1, 5);
      chk("drop_busy", {16'b0, o_drop_count}, 32'd2);

      for (int fr = 0; fr < 25; fr++) begin
         if ($urandom_range(0, 2) == 0) put(1, 0, 1'($urandom_range(0, 1)), 1, rkp());
         put(1, 1, 0, 1'($urandom_range(0, 1)), rkp());
         for (int b = 0; b < int'($urandom_range(0, 8)); b++) begin
            if ($urandom_range(0, 3) == 0)
               put(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, rkp());
            else
               put(1, 0, 0, 1'($urandom_range(0, 1)), rkp());
         end
         if ($urandom_range(0, 3) == 0) put(1, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rkp());
         else                            put(1, 0, 1, 1'($urandom_range(0, 1)), rkp());
         drain(1, ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 30)) : -1);
      end

      put(1, 1, 0, 1, rkp()); put(1, 0, 1, 1, rkp());
      i_ready = 1'b1;
      pkt.delete();
      repeat (5) step();
      #2 i_rst_n = 1'b0;
      #1;
      chk("rst_mid_valid", {31'b0, o_valid}, 32'd0);
      chk("rst_mid_busy", {31'b0, o_busy}, 32'd0);
      chk("rst_mid_drop", {16'b0, o_drop_count}, 32'd0);
      exp_w.delete(); exp_l.delete();
      fid = 0; drops = 0; in_frame = 1'b0;
      idle();
      repeat (2) @(posedge i_clk);
      #1 i_rst_n = 1'b1;
      step();
      put(1, 1, 0, 1, rkp()); put(1, 0, 1, 0, rkp());
      drain(1, -1);
      chk("rst_fid_hdr", pkt[0], 32'h0000_0001);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/brief_desc_collector.md
Name: brief_desc_collector

Overview:
- Receiving end of the BRIEF descriptor stream: consumes the per-pixel keypoint output (flag, coordinates, score, 256-bit descriptor, frame start/end) and stores one frame's keypoints in an internal buffer.
- At frame end, serialises the frame to the host as 32-bit words over a valid/ready handshake: one header word, then 9 words per keypoint.
- Sits between the BRIEF top level and the host/DMA bridge.

Parameters:
- MAX_KP, 256, keypoint entries buffered per frame; must be a power of two, 2..1024.
- FRAME_ID_W, 15, width of the wrapping frame counter placed in the header.

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  asynchronous active-low reset
- i_valid  input  1  qualifies every stream input this cycle
- i_start  input  1  frame start strobe
- i_end  input  1  frame end strobe
- i_flag  input  1  keypoint present this cycle
- i_coor_x  input  10  keypoint column
- i_coor_y  input  10  keypoint row
- i_score  input  8  keypoint score
- i_descriptor  input  256  keypoint descriptor
- o_word  output  32  serial output word
- o_valid  output  1  o_word valid
- i_ready  input  1  host accepts o_word
- o_last  output  1  final word of the frame packet
- o_busy  output  1  high in S_HEADER and S_ENTRY
- o_drop_count  output  16  frames dropped while busy; saturating

Behaviour:
- Reset: state S_IDLE; o_word=0, o_valid=0, o_last=0, o_busy=0, o_drop_count=0; entry count, frame id and overflow flag cleared. Buffer contents need no reset.
- All stream inputs are ignored when i_valid=0. A word transfers when o_valid && i_ready.
- S_IDLE:
  - On i_valid && i_start: go to S_COLLECT; count=0; overflow=0.
  - i_flag in the same cycle as i_start is captured as entry 0.
- S_COLLECT:
  - On i_valid && i_flag && count<MAX_KP: write entry[count] = {score, y, x, descriptor}; count++.
  - On i_valid && i_flag && count==MAX_KP: discard the keypoint; overflow=1.
  - On i_valid && (i_end || i_start): close the frame and go to S_HEADER.
    - A coincident i_flag is captured before closing.
    - If i_start caused the close (back-to-back frames), the new frame is dropped and o_drop_count increments.
- S_HEADER:
  - o_valid=1; o_word = {overflow, frame_id[14:0], count[15:0]}.
  - o_last=1 when count==0.
  - On transfer: go to S_ENTRY with rd_idx=0, word_idx=0. If count==0, go to S_IDLE instead and increment frame_id.
  - o_valid rises the cycle after the closing strobe, giving 1-cycle latency.
- S_ENTRY:
  - word_idx 0: o_word = {4'b0, score, y, x}.
  - word_idx 1..8: descriptor[32*(word_idx-1) +: 32], least significant word first.
  - Advance on transfer. After word_idx 8, increment rd_idx.
  - o_last=1 on word 8 of entry count-1. After that transfer: go to S_IDLE and increment frame_id (wraps).
- Backpressure:
  - o_word, o_valid and o_last hold stable while o_valid && !i_ready.
  - No combinational path from i_ready to o_valid.
- Any i_start seen in S_HEADER or S_ENTRY: that frame is dropped, and o_drop_count increments once per dropped i_start, saturating at 16'hFFFF. i_end/i_flag in these states are ignored.
- i_end in S_IDLE is ignored.
- Asynchronous reset mid-packet aborts the packet immediately; o_valid drops to 0.
- Widths: count is log2(MAX_KP)+1 bits, zero-extended into the header's 16-bit field.

Optional Feature:
- Macro BRIEF_COLLECT_MIN_SCORE_EN.
- Defined:
  - Adds port i_min_score (input, 8): keypoints with i_score < i_min_score are discarded and do not set overflow.
  - Threshold is sampled at frame start and held for the whole frame.
- Undefined: port absent; every flagged keypoint is a candidate.

Test Plan:
- Single frame: start, 3 flags at (5,7,s=20), (100,200,s=30), (639,479,s=255), end; i_ready=1 -> 28 words total.
  - Header 0x00000003.
  - Entry 0 word 0 = 0x01401C05.
  - o_last only on word 28.
- Empty frame: start then end, no flags -> single header 0x00000000 with o_last=1; second empty frame header 0x00010000.
- Overflow, MAX_KP=4: 6 flags -> header bit31=1, count=4, 37 words; entries are the first 4 keypoints.
- Backpressure: i_ready toggles 1,0,0,1 pseudo-randomly -> words identical to the i_ready=1 run, no duplicates or skips, o_word stable while stalled.
- Back-to-back: i_end and i_start in the same cycle -> frame closed; o_drop_count=1; a further i_start during readout -> o_drop_count=2.
- Reset asserted mid-entry readout -> o_valid=0 at once; after release, a new frame header carries frame_id=0.
